conv_mac_stream: RTL and testbench

- Parametrised single-clock streaming multiply-accumulate engine for KxK convolution windows.
- Successor to the fixed 3-tap, wr_clk-fed matrix accumulator:
  - generalised tap count, lane count, data width and FIFO depth;
  - valid/ready handshakes on input and output;
  - signed integer arithmetic.
- Sits between the AXI-stream/DMA input adapter and the result writeback stage.
- Consumes interleaved operand/weight words from an internal FIFO and emits CHANNELS packed window sums per output beat.

---
 rtl/conv_mac_stream.sv | 213 +++++++++++++++++++++
 tb/tb_conv_mac_stream.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_stream.sv
// Streaming signed KxK multiply-accumulate engine: an input FIFO feeds A/B pairs to an FSM that packs CHANNELS window sums per output beat.
// Define CONV_MAC_SAT_EN to saturate each lane to the signed OUT_W range; otherwise lanes wrap.
module conv_mac_stream #(
    parameter int DATA_W     = 16,
    parameter int TAPS       = 9,
    parameter int CHANNELS   = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int OUT_W      = 2 * DATA_W
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          start,
    input  logic                          clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CHANNELS*OUT_W-1:0]     out_data,
    output logic                          busy,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int ACC_W = 2 * DATA_W + $clog2(TAPS) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD_A   = 3'd1;
    localparam logic [2:0] S_LOAD_B   = 3'd2;
    localparam logic [2:0] S_ACCUM    = 3'd3;
    localparam logic [2:0] S_OUT_HOLD = 3'd4;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_next;
    logic [DATA_W-1:0] head;
    logic              push;
    logic              pop;
    logic              pop_req;

    logic [2:0]                state;
    logic [TAP_W-1:0]          tap_cnt;
    logic [CH_W-1:0]           ch_cnt;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [DATA_W-1:0]  reg_a;
    logic signed [DATA_W-1:0]  reg_b;
    logic signed [2*DATA_W-1:0] product;
    logic [OUT_W-1:0]          lane_val;
    logic [OUT_W-1:0]          lane [CHANNELS];

    assign in_ready = !full;
    assign busy     = (state != S_IDLE);
    assign head     = mem[rd_ptr];
    assign pop_req  = ((state == S_LOAD_A) || (state == S_LOAD_B)) && !clear;
    assign pop      = pop_req && !empty;
    assign push     = in_valid && !full && !clear;

    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = fifo_count - CNT_W'(1);
        end
    end

    // Flags are registered from the next count so they are valid the cycle after the push or pop.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= count_next;
            full       <= (count_next == CNT_W'(FIFO_DEPTH));
            empty      <= (count_next == '0);
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    assign product = reg_a * reg_b;
    assign acc_sum = acc + {{(ACC_W - 2 * DATA_W){product[2*DATA_W-1]}}, product};

`ifdef CONV_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(OUT_W - 1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        lane_val = acc_sum[OUT_W-1:0];
        if (acc_sum > SAT_MAX) begin
            lane_val = SAT_MAX[OUT_W-1:0];
        end else if (acc_sum < SAT_MIN) begin
            lane_val = SAT_MIN[OUT_W-1:0];
        end
    end
`else
    always_comb begin
        lane_val = acc_sum[OUT_W-1:0];
    end
`endif

    // The final tap's product is folded in while the lane is written, so acc restarts at zero for the next window.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= S_IDLE;
            tap_cnt   <= '0;
            ch_cnt    <= '0;
            acc       <= '0;
            reg_a     <= '0;
            reg_b     <= '0;
            out_valid <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                lane[k] <= '0;
            end
        end else if (clear) begin
            state     <= S_IDLE;
            tap_cnt   <= '0;
            ch_cnt    <= '0;
            acc       <= '0;
            reg_a     <= '0;
            reg_b     <= '0;
            out_valid <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                lane[k] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD_A;
                    end
                end
                S_LOAD_A: begin
                    if (!empty) begin
                        reg_a <= head;
                        state <= S_LOAD_B;
                    end
                end
                S_LOAD_B: begin
                    if (!empty) begin
                        reg_b <= head;
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (tap_cnt == TAP_LAST) begin
                        lane[ch_cnt] <= lane_val;
                        acc          <= '0;
                        tap_cnt      <= '0;
                        if (ch_cnt == CH_LAST) begin
                            out_valid <= 1'b1;
                            state     <= S_OUT_HOLD;
                        end else begin
                            ch_cnt <= ch_cnt + CH_W'(1);
                            state  <= S_LOAD_A;
                        end
                    end else begin
                        acc     <= acc_sum;
                        tap_cnt <= tap_cnt + TAP_W'(1);
                        state   <= S_LOAD_A;
                    end
                end
                S_OUT_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        ch_cnt    <= '0;
                        state     <= S_LOAD_A;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            out_data[k*OUT_W +: OUT_W] = lane[k];
        end
    end

endmodule

// File: tb/tb_conv_mac_stream.sv
// Self-checking bench for conv_mac_stream (TAPS=3, CHANNELS=2): vector table, hand-written corner sequences and a random run against a queue-based model.
// Expected lane values follow CONV_MAC_SAT_EN the same way the design does.
module tb_conv_mac_stream;

    localparam int DATA_W     = 16;
    localparam int TAPS       = 3;
    localparam int CHANNELS   = 2;
    localparam int FIFO_DEPTH = 16;
    localparam int OUT_W      = 32;
    localparam int WPB        = 2 * TAPS * CHANNELS;

    logic                        Clk;
    logic                        Rst;
    logic                        start;
    logic                        clear;
    logic                        in_valid;
    logic                        in_ready;
    logic [DATA_W-1:0]           in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [CHANNELS*OUT_W-1:0]   out_data;
    logic                        busy;
    logic                        full;
    logic                        empty;
    logic [4:0]                  fifo_count;

    conv_mac_stream #(
        .DATA_W(DATA_W), .TAPS(TAPS), .CHANNELS(CHANNELS),
        .FIFO_DEPTH(FIFO_DEPTH), .OUT_W(OUT_W)
    ) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .full(full), .empty(empty), .fifo_count(fifo_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] w [WPB];
        logic [31:0] lane0;
        logic [31:0] lane1;
    } vec_t;

    vec_t        vecs [4];
    logic [15:0] model_q [$];
    int          n_compared;
    int          n_mismatched;
    int          model_beats;
    logic        last_wr;

`ifdef CONV_MAC_SAT_EN
    localparam logic [31:0] V1_EXP = 32'h7FFFFFFF;
    localparam logic [31:0] V2_EXP = 32'h80000000;
    localparam logic [31:0] V3_EXP = 32'h7FFFFFFF;
`else
    localparam logic [31:0] V1_EXP = 32'hBFFD0003;
    localparam logic [31:0] V2_EXP = 32'h40018000;
    localparam logic [31:0] V3_EXP = 32'hC0000000;
`endif

    // Lane value from the exact window sum: clamp when saturating, else keep the low 32 bits.
    function automatic logic [31:0] resolve(input longint s);
`ifdef CONV_MAC_SAT_EN
        if (s > 64'sd2147483647) return 32'h7FFFFFFF;
        if (s < -64'sd2147483648) return 32'h80000000;
`endif
        return s[31:0];
    endfunction

    function automatic logic [63:0] modelBeat();
        logic [63:0] beat;
        beat = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            longint sum;
            sum = 0;
            for (int t = 0; t < TAPS; t++) begin
                logic signed [15:0] a;
                logic signed [15:0] b;
                a = model_q.pop_front();
                b = model_q.pop_front();
                sum += longint'(a) * longint'(b);
            end
            beat[ch*32 +: 32] = resolve(sum);
        end
        return beat;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL %s: got timeout, expected event", name);
    endtask

    // One clock: record accepted writes and output handshakes, then compare any beat with the model.
    task automatic tick();
        logic        wr;
        logic        fire;
        logic [63:0] od;
        wr   = in_valid && in_ready && !clear && Rst;
        fire = out_valid && out_ready && !clear && Rst;
        od   = out_data;
        @(posedge Clk);
        #1;
        last_wr = wr;
        if (clear) begin
            model_q.delete();
        end else begin
            if (wr) model_q.push_back(in_data);
            if (fire) begin
                model_beats++;
                if (model_q.size() < WPB) begin
                    failNow("model_underflow");
                end else begin
                    checkOutput("model_beat", od, modelBeat());
                end
            end
        end
    endtask

    task automatic waitValid(input int limit, output logic ok);
        int g;
        g = 0;
        while (!out_valid && g < limit) begin
            tick();
            g++;
        end
        ok = out_valid;
        if (!ok) failNow("out_valid_wait");
    endtask

    task automatic doClear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        logic busy_ok;
        logic ok;
        int   g;
        if (!busy) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        busy_ok   = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < WPB; i++) begin
            in_data = v.w[i];
            g = 0;
            while (!in_ready && g < 100) begin
                in_valid = 1'b0;
                tick();
                g++;
            end
            in_valid = 1'b1;
            tick();
            busy_ok &= busy;
        end
        in_valid = 1'b0;
        waitValid(200, ok);
        busy_ok &= busy;
        if (ok) begin
            checkOutput("lane0", {32'd0, out_data[31:0]}, {32'd0, v.lane0});
            checkOutput("lane1", {32'd0, out_data[63:32]}, {32'd0, v.lane1});
        end
        checkOutput("busy_during_window", {63'd0, busy_ok}, 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("out_valid_drop", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        logic        ok;
        logic        stable;
        logic [63:0] held;
        int          written;
        int          cycles;
        int          beats0;

        n_compared   = 0;
        n_mismatched = 0;
        model_beats  = 0;
        last_wr      = 1'b0;
        Rst       = 1'b0;
        start     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;

        vecs[0].w = '{16'd3, 16'd4, 16'hFFFE, 16'd5, 16'd7, 16'd1,
                      16'd100, 16'd1, 16'd200, 16'd2, 16'd300, 16'd3};
        vecs[0].lane0 = 32'd9;
        vecs[0].lane1 = 32'd1400;
        vecs[1].w = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                      16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        vecs[1].lane0 = V1_EXP;
        vecs[1].lane1 = V1_EXP;
        vecs[2].w = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF,
                      16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd1, 16'd5, 16'hFFFA};
        vecs[2].lane0 = V2_EXP;
        vecs[2].lane1 = 32'hFFFFFFE2;
        vecs[3].w = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                      16'd0, 16'h1234, 16'd1, 16'd1, 16'hFFFF, 16'd2};
        vecs[3].lane0 = V3_EXP;
        vecs[3].lane1 = 32'hFFFFFFFF;

        repeat (2) @(posedge Clk);
        #1;
        checkOutput("rst_fifo_count", {59'd0, fifo_count}, 64'd0);
        checkOutput("rst_full",       {63'd0, full},       64'd0);
        checkOutput("rst_empty",      {63'd0, empty},      64'd1);
        checkOutput("rst_in_ready",   {63'd0, in_ready},   64'd1);
        checkOutput("rst_out_valid",  {63'd0, out_valid},  64'd0);
        checkOutput("rst_out_data",   out_data,            64'd0);
        checkOutput("rst_busy",       {63'd0, busy},       64'd0);
        Rst = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i]);
        end

        $display("[TB] backpressure sequence");
        in_valid = 1'b1;
        for (int i = 0; i < WPB; i++) begin
            in_data = vecs[0].w[i];
            tick();
        end
        in_valid = 1'b0;
        waitValid(200, ok);
        held   = out_data;
        stable = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = vecs[2].w[i];
            tick();
            if (out_data !== held || !out_valid) stable = 1'b0;
        end
        checkOutput("hold_stable", {63'd0, stable}, 64'd1);
        checkOutput("hold_count", {59'd0, fifo_count}, 64'd10);
        checkOutput("hold_lanes", held, {vecs[0].lane1, vecs[0].lane0});
        out_ready = 1'b1;
        in_data   = vecs[2].w[10];
        tick();
        out_ready = 1'b0;
        checkOutput("release_valid", {63'd0, out_valid}, 64'd0);
        in_data = vecs[2].w[11];
        tick();
        in_valid = 1'b0;
        waitValid(200, ok);
        checkOutput("resume_lanes", out_data, {vecs[2].lane1, vecs[2].lane0});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        $display("[TB] fifo full sequence");
        doClear();
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 16'($urandom);
            tick();
        end
        checkOutput("full_flag", {63'd0, full}, 64'd1);
        checkOutput("full_count", {59'd0, fifo_count}, 64'd16);
        checkOutput("full_in_ready", {63'd0, in_ready}, 64'd0);
        in_data = 16'hDEAD;
        tick();
        in_valid = 1'b0;
        checkOutput("full_drop_count", {59'd0, fifo_count}, 64'd16);
        checkOutput("full_idle_busy", {63'd0, busy}, 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checkOutput("drain_count", {59'd0, fifo_count}, 64'd15);
        checkOutput("drain_in_ready", {63'd0, in_ready}, 64'd1);
        doClear();
        checkOutput("clear_full_count", {59'd0, fifo_count}, 64'd0);

        $display("[TB] reset mid-window sequence");
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = vecs[3].w[i];
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        Rst = 1'b0;
        #1;
        checkOutput("mid_rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("mid_rst_count", {59'd0, fifo_count}, 64'd0);
        checkOutput("mid_rst_empty", {63'd0, empty}, 64'd1);
        checkOutput("mid_rst_out_data", out_data, 64'd0);
        model_q.delete();
        tick();
        Rst = 1'b1;
        tick();
        applyStimulus(vecs[0]);

        $display("[TB] clear during LOAD_B sequence");
        doClear();
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = vecs[2].w[i];
            tick();
        end
        in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checkOutput("pre_clear_count", {59'd0, fifo_count}, 64'd5);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h5555;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        checkOutput("clear_busy", {63'd0, busy}, 64'd0);
        checkOutput("clear_empty", {63'd0, empty}, 64'd1);
        checkOutput("clear_count", {59'd0, fifo_count}, 64'd0);
        checkOutput("clear_out_valid", {63'd0, out_valid}, 64'd0);
        applyStimulus(vecs[1]);

        $display("[TB] random sequence");
        doClear();
        beats0  = model_beats;
        written = 0;
        cycles  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while ((model_beats - beats0) < 20 && cycles < 20000) begin
            in_valid = (written < 20 * WPB) && ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0:       in_data = ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000;
                default: in_data = 16'($urandom);
            endcase
            out_ready = ($urandom_range(0, 9) < 6);
            tick();
            if (last_wr) written++;
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if ((model_beats - beats0) < 20) failNow("random_beats");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
